// File: rtl/id_ex_ctrl_skid_if.sv
// ID->EX control-bundle handshake interface.
//   ctrlD_i/validD_i/readyD_o : decode-side word, valid and ready
//   flush_i                   : drop every held word
//   ctrlE_o/validE_o/readyE_i : execute-side word, valid and ready
//   clr_cnt_i/stall_cnt_o     : stall counter clear and value
// master = environment driving the stage, slave = the stage itself.
interface id_ex_ctrl_skid_if #(
  parameter int unsigned CTRL_W   = 10,
  parameter int unsigned STALL_CW = 8
);
  logic [CTRL_W-1:0]   ctrlD_i;
  logic                validD_i;
  logic                readyD_o;
  logic                flush_i;
  logic [CTRL_W-1:0]   ctrlE_o;
  logic                validE_o;
  logic                readyE_i;
  logic                clr_cnt_i;
  logic [STALL_CW-1:0] stall_cnt_o;

  modport master (
    output ctrlD_i, validD_i, flush_i, readyE_i, clr_cnt_i,
    input  readyD_o, ctrlE_o, validE_o, stall_cnt_o
  );

  modport slave (
    input  ctrlD_i, validD_i, flush_i, readyE_i, clr_cnt_i,
    output readyD_o, ctrlE_o, validE_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ex_ctrl_skid.sv
// ID->EX control-word pipeline stage with valid/ready handshake.
//   clk_i  : rising-edge clock
//   rst_i  : synchronous active-high reset
//   bus    : id_ex_ctrl_skid_if.slave (decode side, execute side,
//            flush, stall counter clear/value)
// SKID_EN=1 registers readyD_o and parks one extra word in a skid
// entry; SKID_EN=0 keeps a single register with combinational ready.
// ctrlE_o is forced to zero whenever validE_o is low (bubble).
module id_ex_ctrl_skid #(
  parameter int unsigned CTRL_W   = 10,
  parameter bit          SKID_EN  = 1'b1,
  parameter int unsigned STALL_CW = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  id_ex_ctrl_skid_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   main_q, main_d;
  logic [CTRL_W-1:0]   skid_q, skid_d;
  logic                rdy_q, rdy_d;
  logic [STALL_CW-1:0] cnt_q, cnt_d;

  logic                valid_e;
  logic                ready_d;
  logic                in_d;
  logic                out_e;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (bus.flush_i) begin
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_d) begin
            state_d = S_FULL;
            main_d  = bus.ctrlD_i;
          end
        end
        S_FULL: begin
          if (in_d && out_e) begin
            main_d = bus.ctrlD_i;
          end else if (in_d && SKID_EN) begin
            // Only reachable with a registered ready; without the skid
            // entry, accepting while full implies the output drains.
            state_d = S_SKID;
            skid_d  = bus.ctrlD_i;
          end else if (out_e) begin
            state_d = S_EMPTY;
          end
        end
        S_SKID: begin
          if (out_e) begin
            state_d = S_FULL;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
    // Ready is a function of the next state so it leaves a flop.
    rdy_d = (state_d != S_SKID);
  end

  // Outputs and handshake decode
  always_comb begin
    valid_e = (state_q != S_EMPTY);
    if (SKID_EN) begin
      ready_d = rdy_q;
    end else begin
      ready_d = bus.readyE_i | ~valid_e;
    end
    in_d  = bus.validD_i & ready_d;
    out_e = valid_e & bus.readyE_i;
  end

  // Saturating stall counter; clear wins over increment, flush ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_cnt_i) begin
      cnt_d = '0;
    end else if (valid_e && !bus.readyE_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign bus.readyD_o    = ready_d;
  assign bus.validE_o    = valid_e;
  assign bus.ctrlE_o     = valid_e ? main_q : '0;
  assign bus.stall_cnt_o = cnt_q;

endmodule
